trng_uart_tx: RTL and testbench

TRNG_UART_TX -- requirements
Module: trng_uart_tx

---
 rtl/trng_uart_tx.sv | 132 +++++++++++++
 tb/tb_trng_uart_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_uart_tx.sv
// rtl/trng_uart_tx.sv - Flow-controlled UART transmitter with one-byte holding register
module trng_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_dat,
  input  logic       i_write,
  input  logic       i_serial_rts_n,
  output logic       o_ready,
  output logic       o_serial_data,
  output logic       o_new_frame,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shifter;
  logic [7:0]  hold;
  logic        hold_full;
  logic        rts_s1;
  logic        rts_s2;
  logic        rts_ok;
  logic        bit_end;
  logic        stop_done;
  logic        launch;

  // Synchronizer resets to "deasserted" so nothing is sent until the host is seen ready.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rts_s1 <= 1'b1;
      rts_s2 <= 1'b1;
    end else begin
      rts_s1 <= i_serial_rts_n;
      rts_s2 <= rts_s1;
    end
  end

  assign rts_ok    = ~rts_s2;
  assign bit_end   = (cnt == 16'd0);
  assign stop_done = (state == STOP) && bit_end && (bit_idx == STOP_LAST);
  // Flow control is only consulted at byte boundaries, never mid-frame.
  assign launch    = hold_full && rts_ok && ((state == IDLE) || stop_done);
  assign o_busy    = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      cnt           <= 16'd0;
      bit_idx       <= 3'd0;
      shifter       <= 8'd0;
      hold          <= 8'd0;
      hold_full     <= 1'b0;
      o_ready       <= 1'b1;
      o_serial_data <= 1'b1;
      o_new_frame   <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_overrun   <= i_write && !o_ready;
      o_new_frame <= launch;
      if (launch) begin
        shifter       <= hold;
        hold_full     <= 1'b0;
        o_ready       <= 1'b1;
        o_serial_data <= 1'b0;
        state         <= START;
        cnt           <= BIT_LAST;
        bit_idx       <= 3'd0;
      end else begin
        if (i_write && o_ready) begin
          hold      <= i_dat;
          hold_full <= 1'b1;
          o_ready   <= 1'b0;
        end
        case (state)
          IDLE: begin
          end
          START: begin
            if (bit_end) begin
              state         <= DATA;
              o_serial_data <= shifter[0];
              cnt           <= BIT_LAST;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          DATA: begin
            if (bit_end) begin
              cnt <= BIT_LAST;
              if (bit_idx == 3'd7) begin
                state         <= STOP;
                o_serial_data <= 1'b1;
                bit_idx       <= 3'd0;
              end else begin
                bit_idx       <= bit_idx + 3'd1;
                shifter       <= {1'b0, shifter[7:1]};
                o_serial_data <= shifter[1];
              end
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          STOP: begin
            if (bit_end) begin
              if (bit_idx == STOP_LAST) begin
                state <= IDLE;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                cnt     <= BIT_LAST;
              end
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trng_uart_tx.sv
// tb/tb_trng_uart_tx.sv - Self-checking bench for trng_uart_tx with a frame-level line model
module tb_trng_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dat, dat2;
  logic       wr, wr2, rts, rts2;
  logic       ready, line, nf, ov, busy;
  logic       ready2, line2, nf2, ov2, busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int ov_seen  = 0;

  always #5 clk = ~clk;

  trng_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_dat(dat), .i_write(wr), .i_serial_rts_n(rts),
    .o_ready(ready), .o_serial_data(line), .o_new_frame(nf), .o_overrun(ov), .o_busy(busy)
  );

  trng_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_dat(dat2), .i_write(wr2), .i_serial_rts_n(rts2),
    .o_ready(ready2), .o_serial_data(line2), .o_new_frame(nf2), .o_overrun(ov2), .o_busy(busy2)
  );

  always @(negedge clk) if (ov === 1'b1) ov_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line: start bit, 8 data bits LSB first, then stop bits; each CPB cycles long.
  task automatic check_frame(input int sel, input logic [7:0] b, input int stops, input string name);
    int len, pos, bad_at, nf_cnt, busy_low;
    logic exp_bit, l, n, bz, nf_first, l_bad;
    len = (9 + stops) * CPB;
    bad_at = -1; nf_cnt = 0; busy_low = 0; nf_first = 1'b0; l_bad = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      l  = sel ? line2 : line;
      n  = sel ? nf2 : nf;
      bz = sel ? busy2 : busy;
      pos = i / CPB;
      if (pos == 0) exp_bit = 1'b0;
      else if (pos <= 8) exp_bit = b[pos-1];
      else exp_bit = 1'b1;
      if (l !== exp_bit && bad_at < 0) begin bad_at = i; l_bad = l; end
      if (n === 1'b1) nf_cnt++;
      if (i == 0) nf_first = n;
      if (bz !== 1'b1) busy_low++;
    end
    n_checks++;
    if (bad_at >= 0) begin
      n_fail++;
      $display("FAIL %s_line: byte %02h cycle %0d actual %b required %b", name, b, bad_at, l_bad, ~l_bad);
    end
    n_checks++;
    if (!(nf_first === 1'b1 && nf_cnt == 1)) begin
      n_fail++;
      $display("FAIL %s_new_frame: actual first=%b pulses=%0d required first=1 pulses=1", name, nf_first, nf_cnt);
    end
    n_checks++;
    if (busy_low != 0) begin
      n_fail++;
      $display("FAIL %s_busy: actual %0d low cycles required 0", name, busy_low);
    end
  endtask

  task automatic wait_low(input int sel, output int n);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if ((sel ? line2 : line) === 1'b0) begin n = k; break; end
    end
  endtask

  task automatic check_idle(input string name, input int cycles, input logic exp_ready);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (line !== 1'b1 || busy !== 1'b0 || ready !== exp_ready) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: actual %0d non-idle cycles required 0 (ready required %b)", name, bad, exp_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 0; wr2 = 0; dat = 0; dat2 = 0; rts = 1'b1; rts2 = 1'b0;
    @(negedge clk);
    n_checks++; if (line !== 1'b1)  begin n_fail++; $display("FAIL reset_line: actual %b required 1", line); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: actual %b required 1", ready); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: actual %b required 0", busy); end
    n_checks++; if (nf !== 1'b0)    begin n_fail++; $display("FAIL reset_new_frame: actual %b required 0", nf); end
    n_checks++; if (ov !== 1'b0)    begin n_fail++; $display("FAIL reset_overrun: actual %b required 0", ov); end
    @(negedge clk);
    rst_n = 1'b1; rts = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] bytes [4];
    bytes[0] = 8'hA5;
    for (int j = 1; j < 4; j++) bytes[j] = 8'($urandom);
    for (int j = 0; j < 4; j++) begin
      dat = bytes[j]; wr = 1'b1;
      @(negedge clk); wr = 1'b0;
      n_checks++;
      if (ready !== 1'b0 || line !== 1'b1) begin
        n_fail++; $display("FAIL single_ready_low: actual ready=%b line=%b required 0/1", ready, line);
      end
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: actual %b required 1", ready); end
      check_frame(0, bytes[j], 1, "single");
      check_idle("single_idle_after", 3, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2;
    int ov0;
    for (int j = 0; j < 2; j++) begin
      b1 = (j == 0) ? 8'h01 : 8'($urandom);
      b2 = (j == 0) ? 8'hFF : 8'($urandom);
      ov0 = ov_seen;
      dat = b1; wr = 1'b1;
      @(negedge clk); wr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: actual %b required 1", ready); end
      dat = b2; wr = 1'b1;
      fork begin @(negedge clk); wr = 1'b0; end join_none
      check_frame(0, b1, 1, "b2b_first");
      @(negedge clk);
      check_frame(0, b2, 1, "b2b_second");
      n_checks++;
      if (ov_seen != ov0) begin n_fail++; $display("FAIL b2b_overrun: actual %0d pulses required 0", ov_seen - ov0); end
      check_idle("b2b_idle_after", 3, 1'b1);
    end
  endtask

  task automatic test_flow_control();
    int n;
    rts = 1'b1;
    repeat (4) @(negedge clk);
    dat = 8'h55; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    check_idle("flow_held", 10, 1'b0);
    dat = 8'h66; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL flow_overrun_pulse: actual %b required 1", ov); end
    @(negedge clk);
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL flow_overrun_once: actual %b required 0", ov); end
    rts = 1'b0;
    wait_low(0, n);
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL flow_sync_delay: actual %0d required 3", n); end
    if (n > 0) check_frame(0, 8'h55, 1, "flow");
    check_idle("flow_dropped", 40, 1'b1);
  endtask

  task automatic test_rts_midbyte();
    logic [7:0] b2;
    int n;
    b2 = 8'($urandom);
    dat = 8'h3C; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    @(negedge clk);
    dat = b2; wr = 1'b1;
    fork begin @(negedge clk); wr = 1'b0; end join_none
    fork begin repeat (17) @(negedge clk); rts = 1'b1; end join_none
    check_frame(0, 8'h3C, 1, "midbyte");
    check_idle("midbyte_held", 20, 1'b0);
    rts = 1'b0;
    wait_low(0, n);
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL midbyte_resume_delay: actual %0d required 3", n); end
    if (n > 0) check_frame(0, b2, 1, "midbyte_second");
    check_idle("midbyte_idle_after", 3, 1'b1);
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] b3;
    int n;
    dat = 8'($urandom); wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    @(negedge clk);
    dat = 8'($urandom); wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (line !== 1'b1)  begin n_fail++; $display("FAIL async_reset_line: actual %b required 1", line); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: actual %b required 1", ready); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL async_reset_busy: actual %b required 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset_hold_lost", 30, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    b3 = 8'($urandom);
    rst_n = 1'b1; dat = b3; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    wait_low(0, n);
    n_checks++; if (n != 2) begin n_fail++; $display("FAIL reset_release_delay: actual %0d required 2", n); end
    if (n > 0) check_frame(0, b3, 1, "after_reset");
    check_idle("after_reset_idle", 3, 1'b1);
  endtask

  task automatic test_stop2();
    dat2 = 8'h00; wr2 = 1'b1;
    @(negedge clk); wr2 = 1'b0;
    @(negedge clk);
    n_checks++; if (ready2 !== 1'b1) begin n_fail++; $display("FAIL stop2_ready: actual %b required 1", ready2); end
    dat2 = 8'h00; wr2 = 1'b1;
    fork begin @(negedge clk); wr2 = 1'b0; end join_none
    check_frame(1, 8'h00, 2, "stop2_first");
    @(negedge clk);
    check_frame(1, 8'h00, 2, "stop2_second");
    @(negedge clk);
    n_checks++;
    if (line2 !== 1'b1 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL stop2_idle: actual line=%b busy=%b required 1/0", line2, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flow_control();
    test_rts_midbyte();
    test_reset_midbyte();
    test_stop2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
